// File: rtl/data_ram_if.sv
// Load/store bus between the execute stage and the byte-addressable data RAM.
// The core side is the master; the RAM is the slave.
interface data_ram_if #(
  parameter int n      = 32,
  parameter int ADDR_W = 19
);
  logic              ramR;
  logic              ramW;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [n-1:0]      dataW;
  logic [n-1:0]      dataR;
  logic              rvalid;
  logic              err;

  modport master (
    output ramR, ramW, funct3, addr, dataW,
    input  dataR, rvalid, err
  );

  modport slave (
    input  ramR, ramW, funct3, addr, dataW,
    output dataR, rvalid, err
  );
endinterface

// File: rtl/data_ram.sv
// Byte-addressable RV32 data memory: B/H/W loads and stores with lane enables,
// sign/zero extension, misalignment/illegal rejection and 1- or 2-cycle load latency.
module data_ram #(
  parameter int n        = 32,
  parameter int ADDR_W   = 19,
  parameter int READ_LAT = 1
) (
  input  logic      clock,
  input  logic      reset,
  data_ram_if.slave bus
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  if (n != 32) begin : g_bad_n
    $error("data_ram: n must be 32");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("data_ram: READ_LAT must be 1 or 2");
  end

  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? 32'(b) : 32'($signed(b));
      2'b01:   return f3[2] ? 32'(h) : 32'($signed(h));
      default: return w;
    endcase
  endfunction

  logic [n-1:0]      mem [DEPTH];

  logic [ADDR_W-3:0] idx_p0;
  logic [1:0]        lane_p0;
  logic              misal_p0;
  logic              ld_ok_p0;
  logic              st_ok_p0;
  logic              do_load_p0;
  logic              do_store_p0;
  logic              bad_p0;
  logic [3:0]        be_p0;
  logic [31:0]       wdata_p0;

  logic [n-1:0]      word_p1;
  logic [1:0]        lane_p1;
  logic [2:0]        f3_p1;
  logic              vld_p1;
  logic              err_p1;
  logic [n-1:0]      ext_p1;

  logic [n-1:0]      data_out;
  logic              vld_out;
  logic              err_out;

  // Stage p0: request decode, legality and byte-lane write enables
  always_comb begin
    idx_p0   = bus.addr[ADDR_W-1:2];
    lane_p0  = bus.addr[1:0];
    ld_ok_p0 = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_ok_p0 = bus.funct3 inside {3'b000, 3'b001, 3'b010};
    misal_p0 = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
               ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    do_load_p0  = bus.ramR && !bus.ramW && ld_ok_p0 && !misal_p0 && !reset;
    do_store_p0 = bus.ramW && !bus.ramR && st_ok_p0 && !misal_p0 && !reset;
    bad_p0      = (bus.ramR || bus.ramW) && !do_load_p0 && !do_store_p0 && !reset;
    be_p0    = 4'b1111;
    wdata_p0 = bus.dataW;
    case (bus.funct3[1:0])
      2'b00: begin
        be_p0    = 4'b0001 << lane_p0;
        wdata_p0 = {4{bus.dataW[7:0]}};
      end
      2'b01: begin
        be_p0    = lane_p0[1] ? 4'b1100 : 4'b0011;
        wdata_p0 = {2{bus.dataW[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_store_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p0[i]) mem[idx_p0][8*i +: 8] <= wdata_p0[8*i +: 8];
      end
    end
  end

  // Stage p1: synchronous word read with lane/type captured alongside it
  always_ff @(posedge clock) begin
    if (do_load_p0) begin
      word_p1 <= mem[idx_p0];
      lane_p1 <= lane_p0;
      f3_p1   <= bus.funct3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= do_load_p0;
      err_p1 <= bad_p0;
    end
  end

  assign ext_p1 = load_extend(word_p1, lane_p1, f3_p1);

  // Stage p2 (READ_LAT=2 only): extended result registered once more
  if (READ_LAT == 2) begin : g_lat2
    logic [n-1:0] data_p2;
    logic         vld_p2;
    logic         err_p2;

    always_ff @(posedge clock) begin
      if (reset) begin
        data_p2 <= '0;
        vld_p2  <= 1'b0;
        err_p2  <= 1'b0;
      end else begin
        vld_p2 <= vld_p1;
        err_p2 <= err_p1;
        if (vld_p1) data_p2 <= ext_p1;
      end
    end

    assign vld_out  = vld_p2 && !reset;
    assign err_out  = err_p2 && !reset;
    assign data_out = data_p2;
  end else begin : g_lat1
    logic [n-1:0] hold_p2;

    // Last delivered load is kept so dataR holds between results
    always_ff @(posedge clock) begin
      if (reset)       hold_p2 <= '0;
      else if (vld_p1) hold_p2 <= ext_p1;
    end

    assign vld_out  = vld_p1 && !reset;
    assign err_out  = err_p1 && !reset;
    assign data_out = vld_out ? ext_p1 : hold_p2;
  end

  assign bus.dataR  = data_out;
  assign bus.rvalid = vld_out;
  assign bus.err    = err_out;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: one DUT at READ_LAT=1 and one at READ_LAT=2,
// each on its own bus, sharing clock and reset.
module tb_data_ram;
  localparam int AW = 19;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  data_ram_if #(.n(32), .ADDR_W(AW)) b1 ();
  data_ram_if #(.n(32), .ADDR_W(AW)) b2 ();

  data_ram #(.n(32), .ADDR_W(AW), .READ_LAT(1)) u_lat1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1.slave)
  );

  data_ram #(.n(32), .ADDR_W(AW), .READ_LAT(2)) u_lat2 (
    .clock (clock),
    .reset (reset),
    .bus   (b2.slave)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [2:0] f,
                      input logic [AW-1:0] a, input logic [31:0] d);
    b1.ramR = r; b1.ramW = w; b1.funct3 = f; b1.addr = a; b1.dataW = d;
  endtask

  task automatic drv2(input logic r, input logic w, input logic [2:0] f,
                      input logic [AW-1:0] a, input logic [31:0] d);
    b2.ramR = r; b2.ramW = w; b2.funct3 = f; b2.addr = a; b2.dataW = d;
  endtask

  task automatic test_reset();
    drv1(0, 0, 3'b010, '0, '0);
    drv2(0, 0, 3'b010, '0, '0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (b1.dataR !== 32'h0) begin failures++; $display("FAIL reset_dataR1 got=%h exp=%h", b1.dataR, 32'h0); end
    checks++; if (b1.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid1 got=%b exp=0", b1.rvalid); end
    checks++; if (b1.err !== 1'b0) begin failures++; $display("FAIL reset_err1 got=%b exp=0", b1.err); end
    checks++; if (b2.dataR !== 32'h0) begin failures++; $display("FAIL reset_dataR2 got=%h exp=%h", b2.dataR, 32'h0); end
    checks++; if (b2.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid2 got=%b exp=0", b2.rvalid); end
    checks++; if (b2.err !== 1'b0) begin failures++; $display("FAIL reset_err2 got=%b exp=0", b2.err); end
  endtask

  task automatic test_word();
    drv1(0, 1, 3'b010, 19'h10, 32'h8765_4321);
    tick();
    checks++; if (b1.rvalid !== 1'b0 || b1.err !== 1'b0) begin failures++; $display("FAIL sw_no_resp got rvalid=%b err=%b exp 0 0", b1.rvalid, b1.err); end
    drv1(1, 0, 3'b010, 19'h10, '0);
    tick();
    checks++; if (b1.rvalid !== 1'b1) begin failures++; $display("FAIL lw_rvalid got=%b exp=1", b1.rvalid); end
    checks++; if (b1.dataR !== 32'h8765_4321) begin failures++; $display("FAIL lw_data got=%h exp=%h", b1.dataR, 32'h8765_4321); end
    checks++; if (b1.err !== 1'b0) begin failures++; $display("FAIL lw_err got=%b exp=0", b1.err); end
    drv1(0, 0, 3'b010, '0, '0);
    tick();
    checks++; if (b1.rvalid !== 1'b0 || b1.dataR !== 32'h8765_4321) begin failures++; $display("FAIL lw_hold got rvalid=%b data=%h exp 0 %h", b1.rvalid, b1.dataR, 32'h8765_4321); end
  endtask

  task automatic test_byte_lanes();
    logic [2:0]    f3  [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [AW-1:0] ad  [5] = '{19'h10, 19'h12, 19'h12, 19'h12, 19'h10};
    logic [31:0]   exp [5] = '{32'h87AA_4321, 32'hFFFF_FFAA, 32'h0000_00AA,
                               32'hFFFF_87AA, 32'h0000_4321};
    drv1(0, 1, 3'b000, 19'h12, 32'h1234_56AA);
    tick();
    for (int i = 0; i < 5; i++) begin
      drv1(1, 0, f3[i], ad[i], '0);
      tick();
      checks++;
      if (b1.rvalid !== 1'b1 || b1.dataR !== exp[i]) begin
        failures++;
        $display("FAIL lane_load%0d got rvalid=%b data=%h exp 1 %h", i, b1.rvalid, b1.dataR, exp[i]);
      end
    end
    drv1(0, 0, 3'b010, '0, '0);
    tick();
  endtask

  task automatic test_misaligned();
    drv1(0, 1, 3'b001, 19'h11, 32'h0000_BEEF);
    tick();
    checks++; if (b1.err !== 1'b1 || b1.rvalid !== 1'b0) begin failures++; $display("FAIL sh_misal got err=%b rvalid=%b exp 1 0", b1.err, b1.rvalid); end
    checks++; if (b1.dataR !== 32'h0000_4321) begin failures++; $display("FAIL sh_misal_hold got=%h exp=%h", b1.dataR, 32'h0000_4321); end
    drv1(1, 0, 3'b010, 19'h10, '0);
    tick();
    checks++; if (b1.err !== 1'b0 || b1.dataR !== 32'h87AA_4321) begin failures++; $display("FAIL mem_unchanged got err=%b data=%h exp 0 %h", b1.err, b1.dataR, 32'h87AA_4321); end
    drv1(1, 0, 3'b010, 19'h13, '0);
    tick();
    checks++; if (b1.err !== 1'b1 || b1.rvalid !== 1'b0 || b1.dataR !== 32'h87AA_4321) begin failures++; $display("FAIL lw_misal got err=%b rvalid=%b data=%h exp 1 0 %h", b1.err, b1.rvalid, b1.dataR, 32'h87AA_4321); end
    drv1(1, 0, 3'b011, 19'h10, '0);
    tick();
    checks++; if (b1.err !== 1'b1 || b1.rvalid !== 1'b0) begin failures++; $display("FAIL ld_f3_illegal got err=%b rvalid=%b exp 1 0", b1.err, b1.rvalid); end
    drv1(0, 1, 3'b100, 19'h10, 32'hFFFF_FFFF);
    tick();
    checks++; if (b1.err !== 1'b1) begin failures++; $display("FAIL st_f3_illegal got err=%b exp=1", b1.err); end
    drv1(1, 0, 3'b010, 19'h10, '0);
    tick();
    checks++; if (b1.err !== 1'b0 || b1.dataR !== 32'h87AA_4321) begin failures++; $display("FAIL st_f3_nowrite got err=%b data=%h exp 0 %h", b1.err, b1.dataR, 32'h87AA_4321); end
    drv1(0, 0, 3'b010, '0, '0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rv [5] = '{0, 1, 1, 1, 0};
    logic [31:0] exp_d  [5] = '{0, 1, 2, 3, 3};
    for (int i = 0; i < 3; i++) begin
      drv2(0, 1, 3'b010, AW'(4 * i), 32'(i + 1));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drv2(1, 0, 3'b010, AW'(4 * i), '0);
      else       drv2(0, 0, 3'b010, '0, '0);
      tick();
      checks++;
      if (b2.rvalid !== exp_rv[i][0] || (exp_rv[i][0] && b2.dataR !== exp_d[i])) begin
        failures++;
        $display("FAIL b2b_cycle%0d got rvalid=%b data=%h exp %b %h", i, b2.rvalid, b2.dataR, exp_rv[i][0], exp_d[i]);
      end
    end
    checks++; if (b2.dataR !== 32'h3) begin failures++; $display("FAIL b2b_hold got=%h exp=%h", b2.dataR, 32'h3); end
    drv2(1, 0, 3'b010, 19'h2, '0);
    tick();
    drv2(0, 0, 3'b010, '0, '0);
    checks++; if (b2.err !== 1'b0) begin failures++; $display("FAIL lat2_err_early got=%b exp=0", b2.err); end
    tick();
    checks++; if (b2.err !== 1'b1 || b2.rvalid !== 1'b0) begin failures++; $display("FAIL lat2_err got err=%b rvalid=%b exp 1 0", b2.err, b2.rvalid); end
    tick();
    checks++; if (b2.err !== 1'b0) begin failures++; $display("FAIL lat2_err_pulse got=%b exp=0", b2.err); end
  endtask

  task automatic test_hazards();
    drv1(0, 1, 3'b010, 19'h20, 32'h5);
    tick();
    drv1(1, 0, 3'b010, 19'h20, '0);
    tick();
    checks++; if (b1.rvalid !== 1'b1 || b1.dataR !== 32'h5) begin failures++; $display("FAIL raw_hazard got rvalid=%b data=%h exp 1 %h", b1.rvalid, b1.dataR, 32'h5); end
    drv1(1, 0, 3'b010, 19'h20, '0);
    tick();
    drv1(0, 1, 3'b010, 19'h20, 32'h9);
    checks++; if (b1.rvalid !== 1'b1 || b1.dataR !== 32'h5) begin failures++; $display("FAIL war_hazard got rvalid=%b data=%h exp 1 %h", b1.rvalid, b1.dataR, 32'h5); end
    tick();
    drv1(1, 0, 3'b010, 19'h20, '0);
    tick();
    checks++; if (b1.dataR !== 32'h9) begin failures++; $display("FAIL war_store_landed got=%h exp=%h", b1.dataR, 32'h9); end
    drv1(0, 0, 3'b010, '0, '0);
    tick();
  endtask

  task automatic test_reset_mid_load();
    drv1(1, 0, 3'b010, 19'h20, '0);
    drv2(1, 0, 3'b010, 19'h8, '0);
    tick();
    reset = 1'b1;
    drv1(0, 1, 3'b010, 19'h20, 32'hDEAD_BEEF);
    drv2(0, 0, 3'b010, '0, '0);
    #1;
    checks++; if (b1.rvalid !== 1'b0) begin failures++; $display("FAIL rst_cycle_rvalid1 got=%b exp=0", b1.rvalid); end
    tick();
    reset = 1'b0;
    drv1(0, 0, 3'b010, '0, '0);
    #1;
    checks++; if (b1.rvalid !== 1'b0 || b1.dataR !== 32'h0 || b1.err !== 1'b0) begin failures++; $display("FAIL rst_mid1 got rvalid=%b data=%h err=%b exp 0 0 0", b1.rvalid, b1.dataR, b1.err); end
    checks++; if (b2.rvalid !== 1'b0 || b2.dataR !== 32'h0 || b2.err !== 1'b0) begin failures++; $display("FAIL rst_mid2 got rvalid=%b data=%h err=%b exp 0 0 0", b2.rvalid, b2.dataR, b2.err); end
    drv1(1, 0, 3'b010, 19'h20, '0);
    tick();
    checks++; if (b2.rvalid !== 1'b0) begin failures++; $display("FAIL rst_mid2_late got=%b exp=0", b2.rvalid); end
    checks++; if (b1.rvalid !== 1'b1 || b1.dataR !== 32'h9) begin failures++; $display("FAIL mem_kept got rvalid=%b data=%h exp 1 %h", b1.rvalid, b1.dataR, 32'h9); end
    drv1(1, 1, 3'b010, 19'h20, 32'h7);
    tick();
    checks++; if (b1.err !== 1'b1 || b1.rvalid !== 1'b0) begin failures++; $display("FAIL rw_both got err=%b rvalid=%b exp 1 0", b1.err, b1.rvalid); end
    drv1(1, 0, 3'b010, 19'h20, '0);
    tick();
    checks++; if (b1.err !== 1'b0 || b1.dataR !== 32'h9) begin failures++; $display("FAIL rw_both_nowrite got err=%b data=%h exp 0 %h", b1.err, b1.dataR, 32'h9); end
    drv1(0, 0, 3'b010, '0, '0);
    tick();
  endtask

  initial begin
    drv1(0, 0, 3'b010, '0, '0);
    drv2(0, 0, 3'b010, '0, '0);
    test_reset();
    test_word();
    test_byte_lanes();
    test_misaligned();
    test_back_to_back();
    test_hazards();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
